// File: rtl/sa_arbiter.sv
// sa_arbiter: round-robin, ownership-locked sharing of one systolic array.
// Optional ownership watchdog: define SA_ARB_WDOG_EN.
module sa_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int D_W      = 8,
    parameter int SA_R     = 16,
    parameter int SA_C     = 16,
    parameter int M_DIM    = 16,
    parameter int WDOG_CYC = 1024
) (
    input  logic               I_CLK,
    input  logic               I_ASYN_RSTN,
    input  logic [NUM_REQ-1:0] I_REQ,
    input  logic [NUM_REQ-1:0] I_REQ_START,
    input  logic [NUM_REQ-1:0] I_REQ_CLEARN,
    input  logic [D_W-1:0]     I_REQ_MAT_1 [0:NUM_REQ-1][0:SA_R-1][0:M_DIM-1],
    input  logic [D_W-1:0]     I_REQ_MAT_2 [0:NUM_REQ-1][0:M_DIM-1][0:SA_C-1],
    output logic [NUM_REQ-1:0] O_GNT,
    output logic [NUM_REQ-1:0] O_REQ_VLD,
    output logic               O_SA_START,
    output logic               O_SA_CLEARN,
    output logic [D_W-1:0]     O_MAT_1 [0:SA_R-1][0:M_DIM-1],
    output logic [D_W-1:0]     O_MAT_2 [0:M_DIM-1][0:SA_C-1],
    input  logic               I_SA_VLD
`ifdef SA_ARB_WDOG_EN
    ,
    output logic [NUM_REQ-1:0] O_WDOG_ERR
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYC < 2) begin : g_param_chk
        $error("sa_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWITCH = 2'd1,
        S_OWN    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rr_ptr_nxt;
    logic [IW-1:0]      gnt_idx;
    logic [IW-1:0]      gnt_idx_nxt;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      succ_idx;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               pick_vld;
    logic               own_req;
    logic               revoke;

    // Cyclic search from rr_ptr; descending loop lets the nearest hit win.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (I_REQ[IW'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = IW'(idx);
            end
        end
    end

    assign succ_idx = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
    assign own_req  = I_REQ[gnt_idx];

`ifdef SA_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYC + 1);

    logic [CW-1:0] wdog_cnt;

    assign revoke = (state == S_OWN) && own_req && !I_SA_VLD
                 && (wdog_cnt == CW'(WDOG_CYC - 1));

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            wdog_cnt   <= '0;
            O_WDOG_ERR <= '0;
        end else begin
            if (state != S_OWN || I_SA_VLD)
                wdog_cnt <= '0;
            else
                wdog_cnt <= wdog_cnt + 1'b1;
            O_WDOG_ERR <= revoke ? O_GNT : '0;
        end
    end
`else
    assign revoke = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = O_GNT;
        gnt_idx_nxt = gnt_idx;
        rr_ptr_nxt  = rr_ptr;
        unique case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_nxt           = '0;
                    gnt_nxt[pick_idx] = 1'b1;
                    gnt_idx_nxt       = pick_idx;
                    state_nxt         = S_SWITCH;
                end
            end
            S_SWITCH: begin
                if (own_req) begin
                    state_nxt = S_OWN;
                end else begin
                    state_nxt  = S_IDLE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = succ_idx;
                end
            end
            S_OWN: begin
                if (!own_req || revoke) begin
                    state_nxt  = S_IDLE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = succ_idx;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge I_CLK or negedge I_ASYN_RSTN) begin
        if (!I_ASYN_RSTN) begin
            state   <= S_IDLE;
            O_GNT   <= '0;
            gnt_idx <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_nxt;
            O_GNT   <= gnt_nxt;
            gnt_idx <= gnt_idx_nxt;
            rr_ptr  <= rr_ptr_nxt;
        end
    end

    // The switch cycle holds the SA in clear so no partial sums cross owners.
    always_comb begin
        O_SA_START  = 1'b0;
        O_SA_CLEARN = 1'b1;
        O_REQ_VLD   = '0;
        O_MAT_1     = '{default: '0};
        O_MAT_2     = '{default: '0};
        unique case (state)
            S_SWITCH: begin
                O_SA_CLEARN = 1'b0;
                O_MAT_1     = I_REQ_MAT_1[gnt_idx];
                O_MAT_2     = I_REQ_MAT_2[gnt_idx];
            end
            S_OWN: begin
                O_SA_START  = I_REQ_START[gnt_idx];
                O_SA_CLEARN = I_REQ_CLEARN[gnt_idx];
                O_MAT_1     = I_REQ_MAT_1[gnt_idx];
                O_MAT_2     = I_REQ_MAT_2[gnt_idx];
                O_REQ_VLD   = I_SA_VLD ? O_GNT : '0;
            end
            default: ;
        endcase
    end

endmodule
